// File: rtl/nios2_subsystem_nios2_gen2_cpu_div_cell_if.sv
// Handshake and result bundle between the execute stage and the divide cell.
// The master drives the operands and controls, and the slave returns the result and status.
`timescale 1ns/1ps
interface nios2_subsystem_nios2_gen2_cpu_div_cell_if;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic        E_div_start;
  logic        E_div_signed;
  logic        E_div_cancel;
  logic [31:0] M_div_quot;
  logic [31:0] M_div_rem;
  logic        M_div_busy;
  logic        M_div_done;
  logic        M_div_by_zero;

  modport master (
    output E_src1, E_src2, E_div_start, E_div_signed, E_div_cancel,
    input  M_div_quot, M_div_rem, M_div_busy, M_div_done, M_div_by_zero
  );

  modport slave (
    input  E_src1, E_src2, E_div_start, E_div_signed, E_div_cancel,
    output M_div_quot, M_div_rem, M_div_busy, M_div_done, M_div_by_zero
  );
endinterface

// File: rtl/nios2_subsystem_nios2_gen2_cpu_div_cell.sv
// 32-bit radix-2 restoring divider for div/divu. The done pulse follows 34 edges after accept, and new starts are ignored while busy.
// A cancel in LOAD, ITER or FIX aborts the operation and keeps the previous results. Divide by zero returns all-ones and the dividend.
`timescale 1ns/1ps
module nios2_subsystem_nios2_gen2_cpu_div_cell (
  input  logic clk,
  input  logic reset,
  nios2_subsystem_nios2_gen2_cpu_div_cell_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] remo_q, remo_d;
  logic        bz_q, bz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        keep;

  // A kept trial is always below the divisor, so bits 33 and 32 are both clear.
  always_comb begin
    rem_sh = {rem_q, dvd_q[31]};
    trial  = {1'b0, rem_sh} - {2'b00, dsr_q};
    keep   = (trial[33:32] == 2'b00);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    bz_d    = bz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.E_div_start && !bus.E_div_cancel) begin
          state_d = S_LOAD;
          a_d     = bus.E_src1;
          b_d     = bus.E_src2;
          sgn_d   = bus.E_div_signed;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        dvd_d   = (sgn_q && a_q[31]) ? -a_q : a_q;
        dsr_d   = (sgn_q && b_q[31]) ? -b_q : b_q;
        rem_d   = 32'd0;
        cnt_d   = 5'd0;
        qneg_d  = sgn_q & (a_q[31] ^ b_q[31]);
        rneg_d  = sgn_q & a_q[31];
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = keep ? trial[31:0] : rem_sh[31:0];
        dvd_d = {dvd_q[30:0], keep};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (b_q == 32'd0) begin
          quot_d = 32'hFFFF_FFFF;
          remo_d = a_q;
          bz_d   = 1'b1;
        end else begin
          quot_d = qneg_q ? -dvd_q : dvd_q;
          remo_d = rneg_q ? -rem_q : rem_q;
          bz_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A flush abandons the operation before any result is published.
    if (bus.E_div_cancel &&
        (state_q == S_LOAD || state_q == S_ITER || state_q == S_FIX)) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      quot_d  = quot_q;
      remo_d  = remo_q;
      bz_d    = bz_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      rem_q   <= 32'd0;
      dvd_q   <= 32'd0;
      dsr_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= 32'd0;
      remo_q  <= 32'd0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.M_div_quot    = quot_q;
  assign bus.M_div_rem     = remo_q;
  assign bus.M_div_busy    = busy_q;
  assign bus.M_div_done    = done_q;
  assign bus.M_div_by_zero = bz_q;

endmodule

// File: doc/nios2_subsystem_nios2_gen2_cpu_div_cell.md
NIOS2_SUBSYSTEM_NIOS2_GEN2_CPU_DIV_CELL -- requirements
Module: nios2_subsystem_nios2_gen2_cpu_div_cell

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 E_src1  input  32  dividend.
REQ-006 E_src2  input  32  divisor.
REQ-007 E_div_start  input  1  request; sampled only in IDLE.
REQ-008 E_div_signed  input  1  1 = two's-complement operands (div), 0 = unsigned (divu).
REQ-009 E_div_cancel  input  1  pipeline flush; aborts any operation in progress.
REQ-010 M_div_quot  output  32  quotient.
REQ-011 M_div_rem  output  32  remainder.
REQ-012 M_div_busy  output  1  high whenever state is not IDLE.
REQ-013 M_div_done  output  1  one-cycle result-valid pulse.
REQ-014 M_div_by_zero  output  1  divisor was zero; valid with M_div_done.

Function
REQ-015 States SHALL be IDLE, LOAD, ITER, FIX and DONE.
- IDLE->LOAD on E_div_start=1 and E_div_cancel=0.
- LOAD->ITER.
- ITER->FIX after 32 iterations, counted by a 5-bit counter 0..31.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-016 On the accepting edge the block SHALL capture E_src1, E_src2 and E_div_signed; later input changes SHALL NOT affect the result.
REQ-017 LOAD SHALL form operand magnitudes (absolute values when signed=1) and record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
REQ-018 Each ITER cycle SHALL perform one radix-2 restoring step:
- shift {rem,dividend} left by 1;
- subtract the divisor magnitude using a 33-bit trial;
- if the trial is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
REQ-019 FIX SHALL apply the following corrections.
- Negate the quotient if the quotient sign is 1, and negate the remainder if the remainder sign is 1.
- Division truncates toward zero, and the remainder takes the dividend's sign.
REQ-020 FIX SHALL override the result when the divisor is 0, in both modes: quotient=0xFFFFFFFF, remainder=captured dividend, M_div_by_zero=1.
- Otherwise M_div_by_zero=0.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no special flag.
REQ-022 Latency: M_div_done SHALL be high for exactly one cycle, following the 34th rising edge after the edge that accepted E_div_start.
REQ-023 M_div_quot, M_div_rem and M_div_by_zero SHALL be updated on the FIX->DONE edge only.
- They are held stable until the next completed operation or reset.
REQ-024 M_div_busy SHALL be high from the accepting edge through the DONE cycle inclusive.
- E_div_start while busy SHALL be ignored, not queued.
REQ-025 E_div_cancel=1 in LOAD, ITER or FIX SHALL force IDLE on the next edge.
- M_div_done SHALL NOT assert, and the outputs SHALL retain their previous values.
- Cancel in DONE has no effect, because the result is already presented.
REQ-026 E_div_start and E_div_cancel both high in IDLE: cancel wins and the start is dropped.
REQ-027 A new start is accepted in the IDLE cycle immediately after DONE, giving a minimum issue interval of 36 cycles.

Reset
REQ-028 While reset=1 the block SHALL hold the following values, independent of clk:
- state=IDLE and iteration counter=0;
- M_div_quot=0, M_div_rem=0;
- M_div_busy=0, M_div_done=0, M_div_by_zero=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no M_div_done SHALL follow reset release.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-031 Unsigned 100/7 (signed=0) -> done exactly 34 edges after start; quot=0x0000000E, rem=0x00000002, by_zero=0.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; signed 7/-2 -> quot=0xFFFFFFFD, rem=0x00000001.
REQ-033 Divide by zero, 0x12345678/0 in both modes -> quot=0xFFFFFFFF, rem=0x12345678, by_zero=1; latency unchanged.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned 0xFFFFFFFF/0x00010000 -> quot=0x0000FFFF, rem=0x0000FFFF.
REQ-035 Cancel sequence -> busy low after the next edge, no done, outputs unchanged; a new 100/7 start then completes normally.
- Step 1: start 100/7.
- Step 2: pulse E_div_cancel 10 cycles later.
REQ-036 Reset mid-ITER, plus start pulses while busy -> reset clears all outputs to 0 immediately; starts issued during busy produce no extra done pulse.
